// File: rtl/gcd_pkg.sv
// Shared types and constants for the subtractive-Euclid GCD engine.
package gcd_pkg;
    localparam int GCD_WIDTH = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;
endpackage

// File: rtl/gcd_if.sv
// Start/done handshake and operand/result bus for the GCD engine.
interface gcd_if #(
    parameter int WIDTH = gcd_pkg::GCD_WIDTH
);
    logic             start;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;

    modport master (output start, a_in, b_in, input busy, done, result);
    modport slave  (input start, a_in, b_in, output busy, done, result);
endinterface

// File: rtl/gcd_datapath.sv
// Operand registers, compare flags and the two subtractors of the GCD engine.
module gcd_datapath
    import gcd_pkg::*;
#(
    parameter int WIDTH = GCD_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_i,
    input  logic             step_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] a_o,
    output logic [WIDTH-1:0] b_o,
    output logic             a_zero_o,
    output logic             b_zero_o,
    output logic             eq_o,
    output logic             a_gt_b_o
);
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;

    assign a_zero_o = (a_q == '0);
    assign b_zero_o = (b_q == '0);
    assign eq_o     = (a_q == b_q);
    assign a_gt_b_o = (a_q > b_q);
    assign a_o      = a_q;
    assign b_o      = b_q;

    // Only the larger operand is reduced, so neither subtractor can wrap.
    always_comb begin
        a_d = a_q;
        b_d = b_q;
        if (load_i) begin
            a_d = a_i;
            b_d = b_i;
        end else if (step_i) begin
            if (a_gt_b_o) a_d = a_q - b_q;
            else          b_d = b_q - a_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_q <= '0;
            b_q <= '0;
        end else begin
            a_q <= a_d;
            b_q <= b_d;
        end
    end
endmodule

// File: rtl/gcd_engine.sv
// Iterative GCD unit: FSM and held result register around gcd_datapath.
module gcd_engine
    import gcd_pkg::*;
#(
    parameter int WIDTH = GCD_WIDTH
) (
    input  logic  clk,
    input  logic  reset,
    gcd_if.slave  bus
);
    state_e           state_q, state_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             load, step;
    logic [WIDTH-1:0] a_cur, b_cur;
    logic             a_zero, b_zero, eq, a_gt_b;

    gcd_datapath #(.WIDTH(WIDTH)) u_dp (
        .clk      (clk),
        .reset    (reset),
        .load_i   (load),
        .step_i   (step),
        .a_i      (bus.a_in),
        .b_i      (bus.b_in),
        .a_o      (a_cur),
        .b_o      (b_cur),
        .a_zero_o (a_zero),
        .b_zero_o (b_zero),
        .eq_o     (eq),
        .a_gt_b_o (a_gt_b)
    );

    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        load     = 1'b0;
        step     = 1'b0;
        unique case (state_q)
            IDLE: if (bus.start) begin
                load    = 1'b1;
                state_d = CALC;
            end
            CALC: begin
                if (a_zero) begin
                    result_d = b_cur;
                    state_d  = DONE;
                end else if (b_zero || eq) begin
                    result_d = a_cur;
                    state_d  = DONE;
                end else begin
                    step = 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
        end
    end

    // Pure state decodes keep start out of the busy/done timing path.
    assign bus.busy   = (state_q != IDLE);
    assign bus.done   = (state_q == DONE);
    assign bus.result = result_q;
endmodule

// File: tb/tb_gcd_engine.sv
// Scoreboard bench for gcd_engine: result, latency, handshake and reset abort.
module tb_gcd_engine;
    import gcd_pkg::*;

    localparam int W = GCD_WIDTH;

    typedef struct {
        int res;
        int lat;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    gcd_if #(.WIDTH(W)) bus();

    gcd_engine #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int   n_chk = 0;
    int   n_fail = 0;
    int   busy_cnt = 0;
    int   last_res = 0;
    bit   prev_done = 1'b0;
    exp_t sbq[$];
    exp_t mon_e;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference result by modulo Euclid, independent of the subtractive walk.
    function automatic int ref_gcd(input int a, input int b);
        int t;
        while (b != 0) begin
            t = a % b;
            a = b;
            b = t;
        end
        return a;
    endfunction

    // CALC cycles = subtract steps + 1.
    function automatic int calc_cycles(input int a, input int b);
        int n = 1;
        while (a != 0 && b != 0 && a != b) begin
            if (a > b) a = a - b;
            else       b = b - a;
            n++;
        end
        return n;
    endfunction

    task automatic push(input int a, input int b);
        exp_t e;
        e.res = ref_gcd(a, b);
        e.lat = calc_cycles(a, b) + 1;
        sbq.push_back(e);
    endtask

    task automatic run(input int a, input int b);
        int k = 0;
        while (bus.busy && k < 100) begin
            @(negedge clk);
            k++;
        end
        if (bus.busy) chk("idle_timeout", 0, 1);
        bus.a_in  = W'(a);
        bus.b_in  = W'(b);
        bus.start = 1'b1;
        push(a, b);
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int k = 0;
        while (!bus.done && k < 100) begin
            @(negedge clk);
            k++;
        end
        if (!bus.done) chk({tag, "_timeout"}, 0, 1);
    endtask

    // Monitor: pops the scoreboard on every done pulse.
    initial forever begin
        @(negedge clk);
        if (reset) begin
            busy_cnt  = 0;
            prev_done = 1'b0;
            last_res  = 0;
        end else begin
            if (bus.busy) busy_cnt++;
            if (prev_done) chk("done_width", bus.done, 0);
            if (bus.busy && !bus.done) chk("res_stable", bus.result, last_res);
            if (bus.done) begin
                if (sbq.size() == 0) begin
                    chk("spurious_done", 1, 0);
                end else begin
                    mon_e = sbq.pop_front();
                    chk("result", bus.result, mon_e.res);
                    chk("latency", busy_cnt, mon_e.lat);
                end
                last_res = int'(bus.result);
                busy_cnt = 0;
            end
            prev_done = bus.done;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bus.start = 1'b0;
        bus.a_in  = '0;
        bus.b_in  = '0;
        repeat (2) @(negedge clk);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_result", bus.result, 0);
        reset = 1'b0;
        @(negedge clk);

        run(12, 18); wait_done("basic");
        run(31, 1);  wait_done("worst_a");
        run(1, 31);  wait_done("worst_b");
        run(0, 7);   wait_done("zero_a");
        run(9, 0);   wait_done("zero_b");
        run(0, 0);   wait_done("zero_both");
        run(17, 17); wait_done("equal");

        // Start pulse and operand changes while busy must be ignored.
        run(20, 30);
        bus.a_in  = 5'd5;
        bus.b_in  = 5'd3;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        bus.a_in  = 5'd1;
        bus.b_in  = 5'd2;
        wait_done("ignore");
        repeat (3) @(negedge clk);
        chk("ignored_idle", bus.busy, 0);
        chk("result_hold", bus.result, 10);

        // Start held through DONE restarts from IDLE with the operands present then.
        bus.a_in  = 5'd8;
        bus.b_in  = 5'd12;
        bus.start = 1'b1;
        push(8, 12);
        wait_done("hold1");
        bus.a_in = 5'd14;
        bus.b_in = 5'd21;
        push(14, 21);
        @(negedge clk);
        chk("hold_idle", bus.busy, 0);
        @(negedge clk);
        chk("hold_restart", bus.busy, 1);
        bus.start = 1'b0;
        wait_done("hold2");

        // Asynchronous reset mid-cycle during CALC cycle 5 aborts the operation.
        run(31, 2);
        repeat (4) @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk("abort_busy", bus.busy, 0);
        chk("abort_done", bus.done, 0);
        chk("abort_result", bus.result, 0);
        sbq.delete();
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_idle", bus.busy, 0);
        run(28, 21); wait_done("after_reset");

        for (int i = 0; i < 6; i++) begin
            run(int'($urandom_range(0, 31)), int'($urandom_range(0, 31)));
            wait_done("random");
        end

        repeat (3) @(negedge clk);
        chk("sb_empty", sbq.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/gcd_engine.md
Name: gcd_engine

Overview:
Iterative subtractive-Euclid GCD unit for two unsigned WIDTH-bit operands, driven by a start/done handshake. Operands come from board switches or an upstream register. The held result drives the 5-bit input of the two-digit decimal seven-segment display decoder on the MAX10 board. One subtract or compare step per clock; the result is held stable between operations so the display never flickers.

Parameters:
WIDTH, 5, operand and result width in bits; the default matches the display decoder input (values 0..31).

Ports:
clk  input  1  system clock; all state changes on its rising edge.
reset  input  1  asynchronous, active-high reset; clears all state immediately.
start  input  1  request a new computation; sampled only in IDLE.
a_in  input  WIDTH  operand A; captured on the edge that accepts start.
b_in  input  WIDTH  operand B; captured on the edge that accepts start.
busy  output  1  high while in CALC or DONE.
done  output  1  one-cycle pulse; result is valid from this cycle onward.
result  output  WIDTH  GCD of the last accepted operand pair; held until the next accepted start.

Behaviour:
- Reset (async assert, any state): state=IDLE, internal a=0, b=0, result=0, busy=0, done=0.
- Reset deassertion must be synchronised to clk externally; the block itself only requires async assert.
- States:
  - IDLE: busy=0, done=0. If start=1 at a rising edge: a<=a_in, b<=b_in, go to CALC. result is unchanged until DONE.
  - CALC: busy=1. Each edge evaluates in priority order:
    1. a==0: result<=b, go to DONE.
    2. b==0: result<=a, go to DONE.
    3. a==b: result<=a, go to DONE.
    4. a>b: a<=a-b, stay in CALC.
    5. otherwise: b<=b-a, stay in CALC.
  - DONE: busy=1, done=1 for exactly one cycle; unconditionally return to IDLE on the next edge.
- Datapath arithmetic:
  - Unsigned WIDTH-bit compare and subtract.
  - Subtraction is only performed from the larger operand, so it never wraps.
- Latency: N CALC cycles + 1 DONE cycle after the accepting edge.
  - N = (number of subtract steps) + 1.
  - Worst case for WIDTH=5 is (31,1) or (1,31): 30 subtracts + 1 = 31 CALC cycles.
- gcd(0,0) = 0, completing in 1 CALC cycle. No error flag.
- start while busy=1 is ignored, including start held high through DONE. A start still high in IDLE begins a new computation on that edge; back-to-back operation is legal.
- a_in/b_in changes after capture have no effect on the computation in progress.
- Reset during CALC or DONE aborts the computation: result=0, and no done pulse is produced.
- done and busy are registered state decodes, with no combinational path from start.

Decomposition:
- Shared package gcd_pkg:
  - state enum {IDLE, CALC, DONE}, 2-bit encoding.
  - GCD_WIDTH constant = 5, used as the WIDTH default.
- One natural sub-module, gcd_datapath:
  - Contains the a/b registers, the equality/zero/greater compare, and the two subtractors.
  - Control inputs: load, step.
  - Status outputs: a_zero, b_zero, eq, a_gt_b.
- The FSM and the result register stay in gcd_engine.

Test Plan:
- Basic: reset, then start with a_in=12, b_in=18 → 3 CALC cycles (b=6, a=6, equal); done pulses once with result=6; busy high for 4 cycles.
- Worst case: a_in=31, b_in=1 → result=1 after exactly 31 CALC cycles + 1 DONE. Repeat with (1,31) → same result and latency.
- Zero and equal operands:
  - (0,7) → result=7 after 1 CALC cycle.
  - (9,0) → result=9 after 1 CALC cycle.
  - (0,0) → result=0 after 1 CALC cycle.
  - (17,17) → result=17 after 1 CALC cycle.
- Handshake:
  - Start (20,30) → result=10.
  - Pulse start with (5,3) during CALC → ignored; result stays 10 and exactly one done pulse occurs.
  - Hold start high through DONE → second computation begins in IDLE.
  - Changing a_in/b_in during CALC does not alter result.
- Reset mid-operation: start (31,2), assert reset on CALC cycle 5 asynchronously (mid-cycle) → busy, done and result go to 0 immediately with no done pulse. After release, start (28,21) → result=7.
